// File: rtl/lsu_pipelined.sv
// lsu_pipelined: Wishbone B4 pipelined data-port master with in-order responses.
// Define LSU_TIMEOUT_EN to add the hung-slave watchdog and the ABORT drain state.
module lsu_pipelined #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_we_o,
    output logic                  rsp_err_o,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_lock,
    output logic                  wb_we,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic [DATA_W/8-1:0]   wb_sel,
    output logic [DATA_W-1:0]     wb_wdata,
    input  logic [DATA_W-1:0]     wb_rdata,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    input  logic                  wb_stall
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

`ifdef LSU_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, ABORT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] type_q;

    logic stb;
    logic accept;
    logic bus_retire;
    logic retire;
    logic abort_rsp;
    logic head_we;

`ifdef LSU_TIMEOUT_EN
    logic [WD_W-1:0] wd_q;
    logic            wd_expire;
`endif

    // Issue, accept and retire decisions; stb depends only on registered count, never on ack
    always_comb begin
        stb        = 1'b0;
        accept     = 1'b0;
        bus_retire = 1'b0;
        retire     = 1'b0;
        abort_rsp  = 1'b0;
        head_we    = type_q[rd_ptr_q];

        stb = rstn_i && req_i && (count_q < MAX_CNT);
`ifdef LSU_TIMEOUT_EN
        if (state_q == ABORT) begin
            stb = 1'b0;
        end
        abort_rsp = rstn_i && (state_q == ABORT) && (count_q != '0);
`endif
        accept     = stb && !wb_stall;
        bus_retire = rstn_i && (state_q == BUS) && (wb_ack || wb_err) && (count_q != '0);
        retire     = bus_retire || abort_rsp;
    end

    always_comb begin
        count_d = count_q;
        case ({accept, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    assign wd_expire = (state_q == BUS) && (count_q != '0) && !accept && !retire && (wd_q == WD_LAST);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if ((count_d == '0) && !accept) begin
                    state_d = IDLE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = ABORT;
                end
`endif
            end
`ifdef LSU_TIMEOUT_EN
            ABORT: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Bus lines are zeroed whenever no strobe is presented
    always_comb begin
        wb_stb      = stb;
        wb_cyc      = stb || (state_q == BUS);
        wb_lock     = 1'b0;
        wb_we       = stb && we_i;
        wb_addr     = stb ? addr_i : '0;
        wb_wdata    = stb ? wdata_i : '0;
        wb_sel      = '0;
        if (stb) begin
            wb_sel = we_i ? be_i : '1;
        end
        req_ready_o = accept;
        rsp_valid_o = retire;
        rsp_we_o    = retire && head_we;
        rsp_err_o   = (bus_retire && wb_err) || abort_rsp;
        rsp_rdata_o = (bus_retire && !head_we && !wb_err) ? wb_rdata : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            type_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                type_q[wr_ptr_q] <= we_i;
                wr_ptr_q         <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (retire) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Watchdog measures cycles without any bus progress while requests are in flight
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wd_q <= '0;
        end else if ((state_q == BUS) && (count_q != '0) && !accept && !retire && !wd_expire) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_pipelined.sv
// tb_lsu_pipelined: directed self-checking bench for lsu_pipelined in its default build.
// The Wishbone slave is modelled directly by the stimulus steps.
module tb_lsu_pipelined;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_we_o;
    logic        rsp_err_o;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_lock;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    int vectors     = 0;
    int miscompares = 0;

    lsu_pipelined #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .be_i(be_i),
        .wdata_i(wdata_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_we_o(rsp_we_o),
        .rsp_err_o(rsp_err_o),
        .wb_cyc(wb_cyc),
        .wb_stb(wb_stb),
        .wb_lock(wb_lock),
        .wb_we(wb_we),
        .wb_addr(wb_addr),
        .wb_sel(wb_sel),
        .wb_wdata(wb_wdata),
        .wb_rdata(wb_rdata),
        .wb_ack(wb_ack),
        .wb_err(wb_err),
        .wb_stall(wb_stall)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; checks follow 1 time unit later, well clear of the rising edge
    task automatic applyStimulus(input logic rstn, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic ack, input logic err,
                                 input logic stall, input logic [31:0] rdata);
        @(negedge clk_i);
        rstn_i   = rstn;
        req_i    = req;
        we_i     = we;
        addr_i   = addr;
        be_i     = be;
        wdata_i  = wdata;
        wb_ack   = ack;
        wb_err   = err;
        wb_stall = stall;
        wb_rdata = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_rdata = '0;

        // Reset
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rst_cyc", wb_cyc, 0);
        checkOutput("rst_stb", wb_stb, 0);
        checkOutput("rst_lock", wb_lock, 0);
        checkOutput("rst_ready", req_ready_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);

        // Single load, acked two cycles after acceptance
        applyStimulus(1, 1, 0, 32'h100, 4'h5, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("ld_stb", wb_stb, 1);
        checkOutput("ld_cyc", wb_cyc, 1);
        checkOutput("ld_ready", req_ready_o, 1);
        checkOutput("ld_addr", wb_addr, 32'h100);
        checkOutput("ld_sel", wb_sel, 4'hF);
        checkOutput("ld_we", wb_we, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("ld_wait_cyc", wb_cyc, 1);
        checkOutput("ld_wait_stb", wb_stb, 0);
        checkOutput("ld_wait_addr", wb_addr, 32'h0);
        checkOutput("ld_wait_rsp", rsp_valid_o, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'hDEADBEEF);
        checkOutput("ld_rsp_valid", rsp_valid_o, 1);
        checkOutput("ld_rsp_we", rsp_we_o, 0);
        checkOutput("ld_rsp_err", rsp_err_o, 0);
        checkOutput("ld_rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("ld_cyc_drop", wb_cyc, 0);

        // Four back-to-back stores with zero-wait acks
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 32'h200 + 32'(4 * i), 4'b0011, 32'h1000 + 32'(i),
                          (i > 0), 0, 0, 32'hBAD0BAD0);
            checkOutput("st_ready", req_ready_o, 1);
            checkOutput("st_cyc", wb_cyc, 1);
            checkOutput("st_sel", wb_sel, 4'b0011);
            checkOutput("st_we", wb_we, 1);
            checkOutput("st_wdata", wb_wdata, 32'h1000 + 32'(i));
            checkOutput("st_rsp_valid", rsp_valid_o, (i > 0));
            if (i > 0) begin
                checkOutput("st_rsp_we", rsp_we_o, 1);
                checkOutput("st_rsp_rdata", rsp_rdata_o, 32'h0);
            end
        end
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'hBAD0BAD0);
        checkOutput("st_last_rsp", rsp_valid_o, 1);
        checkOutput("st_last_we", rsp_we_o, 1);
        checkOutput("st_last_cyc", wb_cyc, 1);
        checkOutput("st_last_stb", wb_stb, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("st_cyc_drop", wb_cyc, 0);

        // Fill to MAX_OUTSTANDING with no acks, then free one slot
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 32'h300 + 32'(4 * i), 4'h0, 32'h0, 0, 0, 0, 32'h0);
            checkOutput("full_fill_ready", req_ready_o, 1);
        end
        applyStimulus(1, 1, 0, 32'h310, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("full_stb", wb_stb, 0);
        checkOutput("full_ready", req_ready_o, 0);
        checkOutput("full_cyc", wb_cyc, 1);
        applyStimulus(1, 1, 0, 32'h310, 4'h0, 32'h0, 1, 0, 0, 32'hA0);
        checkOutput("full_ack_stb", wb_stb, 0);
        checkOutput("full_ack_rsp", rsp_valid_o, 1);
        checkOutput("full_ack_rdata", rsp_rdata_o, 32'hA0);
        applyStimulus(1, 1, 0, 32'h310, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("full_reissue_stb", wb_stb, 1);
        checkOutput("full_reissue_ready", req_ready_o, 1);
        checkOutput("full_reissue_addr", wb_addr, 32'h310);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'hB0 + 32'(i));
            checkOutput("full_drain_rsp", rsp_valid_o, 1);
            checkOutput("full_drain_rdata", rsp_rdata_o, 32'hB0 + 32'(i));
        end
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("full_cyc_drop", wb_cyc, 0);

        // Slave stalls the first request for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 32'h400, 4'hF, 32'hCAFEF00D, 0, 0, 1, 32'h0);
            checkOutput("stall_ready", req_ready_o, 0);
            checkOutput("stall_stb", wb_stb, 1);
            checkOutput("stall_cyc", wb_cyc, 1);
            checkOutput("stall_addr", wb_addr, 32'h400);
            checkOutput("stall_wdata", wb_wdata, 32'hCAFEF00D);
        end
        applyStimulus(1, 1, 1, 32'h400, 4'hF, 32'hCAFEF00D, 0, 0, 0, 32'h0);
        checkOutput("stall_accept", req_ready_o, 1);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("stall_inflight_cyc", wb_cyc, 1);
        checkOutput("stall_inflight_rsp", rsp_valid_o, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0);
        checkOutput("stall_rsp", rsp_valid_o, 1);
        checkOutput("stall_rsp_we", rsp_we_o, 1);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("stall_cyc_drop", wb_cyc, 0);

        // Load / store(err) / load, then spurious ack and err while idle
        applyStimulus(1, 1, 0, 32'h500, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("mix_ld1_ready", req_ready_o, 1);
        applyStimulus(1, 1, 1, 32'h504, 4'h1, 32'h55, 1, 0, 0, 32'h12345678);
        checkOutput("mix_st_ready", req_ready_o, 1);
        checkOutput("mix_st_sel", wb_sel, 4'h1);
        checkOutput("mix_ld1_rsp", rsp_valid_o, 1);
        checkOutput("mix_ld1_we", rsp_we_o, 0);
        checkOutput("mix_ld1_err", rsp_err_o, 0);
        checkOutput("mix_ld1_rdata", rsp_rdata_o, 32'h12345678);
        applyStimulus(1, 1, 0, 32'h508, 4'h0, 32'h0, 0, 1, 0, 32'hFFFFFFFF);
        checkOutput("mix_ld2_ready", req_ready_o, 1);
        checkOutput("mix_st_rsp", rsp_valid_o, 1);
        checkOutput("mix_st_we", rsp_we_o, 1);
        checkOutput("mix_st_err", rsp_err_o, 1);
        checkOutput("mix_st_rdata", rsp_rdata_o, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h9ABCDEF0);
        checkOutput("mix_ld2_rsp", rsp_valid_o, 1);
        checkOutput("mix_ld2_we", rsp_we_o, 0);
        checkOutput("mix_ld2_err", rsp_err_o, 0);
        checkOutput("mix_ld2_rdata", rsp_rdata_o, 32'h9ABCDEF0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("mix_cyc_drop", wb_cyc, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h77);
        checkOutput("spur_ack_rsp", rsp_valid_o, 0);
        checkOutput("spur_ack_rdata", rsp_rdata_o, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("spur_err_rsp", rsp_valid_o, 0);
        checkOutput("spur_err_err", rsp_err_o, 0);
        applyStimulus(1, 1, 0, 32'h600, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("post_spur_ready", req_ready_o, 1);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h600D);
        checkOutput("post_spur_rsp", rsp_valid_o, 1);
        checkOutput("post_spur_rdata", rsp_rdata_o, 32'h600D);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("post_spur_cyc_drop", wb_cyc, 0);

        // Reset with two loads in flight drops them
        applyStimulus(1, 1, 0, 32'h700, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rstmid_ld1_ready", req_ready_o, 1);
        applyStimulus(1, 1, 0, 32'h704, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rstmid_ld2_ready", req_ready_o, 1);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h1);
        checkOutput("rstmid_rsp_in_reset", rsp_valid_o, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rstmid_cyc", wb_cyc, 0);
        checkOutput("rstmid_stb", wb_stb, 0);
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h2);
        checkOutput("rstmid_dropped_ack", rsp_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_pipelined.md
Name: lsu_pipelined

Overview:
- Parametrised successor to the core's single-request load/store unit.
- Acts as a Wishbone B4 pipelined master on the data port.
- Issues back-to-back requests and tracks up to MAX_OUTSTANDING in-flight transactions.
- Returns one in-order response per request, with an error flag and the request type.
- Sits between the core's memory stage and the data-side interconnect.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; must be a multiple of 8
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests; at least 1
TIMEOUT_CYCLES, 256, watchdog limit; used only with LSU_TIMEOUT_EN

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
req_i  in  1  core request valid
we_i  in  1  1 = store, 0 = load
addr_i  in  ADDR_W  byte address
be_i  in  DATA_W/8  store byte enables
wdata_i  in  DATA_W  store data
req_ready_o  out  1  request accepted this cycle
rsp_valid_o  out  1  response valid
rsp_rdata_o  out  DATA_W  load data; 0 for stores and errors
rsp_we_o  out  1  type of the request being retired
rsp_err_o  out  1  bus error or timeout
wb_if  master  -  Wishbone pipelined interface: cyc, stb, lock, we, addr, sel, wdata, rdata, ack, err, stall

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-low on rstn_i.
- Reset values:
  - state = IDLE, outstanding count = 0, type FIFO empty.
  - All outputs 0; wb_if.cyc, wb_if.stb, wb_if.lock = 0.
- Issue:
  - stb = req_i && (count < MAX_OUTSTANDING) && state != ABORT.
  - Address, data and control lines are driven combinationally from the core inputs while stb = 1, and are 0 otherwise.
  - sel = be_i for stores and all-ones for loads.
- Accept:
  - req_ready_o = stb && !wb_if.stall.
  - On acceptance, count increments and we_i is pushed into the type FIFO (depth MAX_OUTSTANDING).
  - The core holds its request stable while req_i && !req_ready_o.
- Retire:
  - A retire event is (ack || err) && count > 0.
  - On a retire event, count decrements and the FIFO pops.
  - rsp_valid_o = 1, rsp_we_o = FIFO head, rsp_err_o = err.
  - rsp_rdata_o = wb_if.rdata only for a load with no error; 0 otherwise.
  - Response latency is zero: the response is combinational from ack/err. At most one retire per cycle.
- Simultaneous accept and retire: count is unchanged; the FIFO pushes and pops in the same cycle.
- Full condition: when count == MAX_OUTSTANDING, stb = 0, even if an ack arrives that same cycle. No comb path from ack to stb.
- Spurious ack/err with count == 0: ignored, no response, no underflow.
- lock is held at 0.
- State machine:
  - IDLE: cyc = 0. Go to BUS when req_i.
  - BUS: cyc = 1. Return to IDLE when, after this cycle's accept/retire, count == 0 and there is no accept this cycle.
  - ABORT: only exists with the optional feature.
- cyc rises in the same cycle as the first stb; stb is never asserted without cyc.
- Reset mid-operation: count and FIFO are cleared. cyc and stb drop in the cycle after the reset edge. Pending acks are dropped.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter runs in BUS while count > 0. It clears on any retire event or accept.
  - When it reaches TIMEOUT_CYCLES-1, the FSM enters ABORT: cyc = 0, stb = 0, req_ready_o = 0.
  - In ABORT, one response per cycle is emitted with rsp_err_o = 1, rsp_rdata_o = 0 and rsp_we_o from the FIFO head, until count == 0.
  - The FSM then returns to IDLE. Bus acks during ABORT are ignored.
- Without the macro: no watchdog and no ABORT state; a hung slave stalls forever.

Test Plan:
- Single load: addr 0x100, slave acks 2 cycles later with 0xDEADBEEF -> rsp_valid_o=1, rsp_we_o=0, rdata 0xDEADBEEF; cyc drops the next cycle.
- Burst of 4 stores (be 4'b0011), zero-wait acks -> four responses in order, rsp_we_o=1, count never exceeds 1, cyc held continuously.
- MAX_OUTSTANDING=4, slave withholds ack -> 4 accepts, then stb=0 and req_ready_o=0. One ack -> stb reasserts the next cycle and the 5th request is accepted.
- Stall for 3 cycles on the first request -> req_ready_o=0 for 3 cycles with addr/wdata stable; accepted on cycle 4, count=1.
- Mixed load/store/load with err on the store -> responses: load data, store with err=1 and rdata=0, load data; also a spurious ack with count=0 gives no response.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, 2 loads in flight with no ack -> cyc=0 after 8 cycles, then 2 consecutive err responses, then IDLE and a new request is accepted.
